// File: rtl/onehot_scan_enc32.sv
// Multi-hot to index scanner: captures a request vector, then emits the index of each
// set bit (lowest first) through a valid/ready handshake and pulses done when exhausted.
module onehot_scan_enc32 #(
    parameter int unsigned N     = 32,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   count
);

    localparam int unsigned CntW = IDX_W + 1;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CntW-1:0]  count_q, count_d;

    // Priority select: the last assignment in the descending loop wins, giving the LSB.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        count_d     = count_q;

        unique case (state_q)
            StIdle: begin
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                if (load && en) begin
                    pending_d = req;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    if (req != '0) begin
                        state_d     = StScan;
                        out_valid_d = 1'b1;
                        out_idx_d   = lowest_set(req);
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StScan: begin
                if (out_valid_q && out_ready) begin
                    pending_d[out_idx_q] = 1'b0;
                    count_d              = count_q + CntW'(1);
                    if (pending_d != '0) begin
                        out_idx_d = lowest_set(pending_d);
                    end else begin
                        state_d     = StDone;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d     = StIdle;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
            default: begin
                state_d     = StIdle;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                pending_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule

// File: tb/tb_onehot_scan_enc32.sv
// Scoreboard bench for onehot_scan_enc32: the driver pushes the expected index stream and
// final count per vector; a negedge monitor pops and compares as the DUT presents them.
module tb_onehot_scan_enc32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [31:0] req = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_idx;
    logic        busy;
    logic        done;
    logic [5:0]  count;

    int n_chk = 0;
    int n_pass = 0;

    int exp_idx[$];
    int exp_cnt[$];

    onehot_scan_enc32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail(input string name, input int act, input int exp);
        n_chk++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: every set bit in ascending order, and the population count.
    task automatic push_expected(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                exp_idx.push_back(i);
                n++;
            end
        end
        exp_cnt.push_back(n);
    endtask

    // Monitor
    initial begin
        logic       pv, pr, pd;
        logic [4:0] pidx;
        int         e;
        pv = 0; pr = 0; pd = 0; pidx = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0; pr = 0; pd = 0;
                continue;
            end
            if (pv && !pr) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_idx", 32'(out_idx), 32'(pidx));
            end
            if (out_valid) begin
                if (exp_idx.size() == 0) begin
                    fail("unexpected_valid_idx", int'(out_idx), -1);
                end else if (out_ready) begin
                    e = exp_idx.pop_front();
                    chk("idx", 32'(out_idx), 32'(e));
                end else begin
                    chk("idx_waiting", 32'(out_idx), 32'(exp_idx[0]));
                end
            end
            if (done) begin
                if (pd) fail("done_width_cycles", 2, 1);
                if (exp_cnt.size() == 0) begin
                    fail("unexpected_done_count", int'(count), -1);
                end else begin
                    e = exp_cnt.pop_front();
                    chk("count_at_done", 32'(count), 32'(e));
                end
                chk("busy_at_done", 32'(busy), 32'd1);
                chk("valid_at_done", 32'(out_valid), 32'd0);
                chk("indices_left_at_done", 32'(exp_idx.size()), 32'd0);
            end
            pv = out_valid; pr = out_ready; pidx = out_idx; pd = done;
        end
    end

    // mode: 0 ready always high, 1 toggling, 2 random. junk: hammer load/req during scan.
    task automatic run_vec(input logic [31:0] v, input int mode, input bit junk);
        int  cyc;
        bit  finished;
        push_expected(v);
        @(posedge clk); #1;
        en = 1'b1; load = 1'b1; req = v;
        out_ready = (mode == 1) ? 1'b0 : 1'b1;
        cyc = 0; finished = 0;
        while (!finished && cyc < 400) begin
            @(posedge clk); #1;
            load = junk;
            en   = junk ? 1'b1 : 1'($urandom_range(0, 1));
            req  = $urandom;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (done) finished = 1;
            cyc++;
        end
        if (!finished) fail("done_timeout_cycles", cyc, -1);
        @(posedge clk); #1;
        load = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("count_hold", 32'(count), 32'($countones(v)));
    endtask

    initial begin
        logic [31:0] v;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        #20 rst_n = 1'b1;

        run_vec(32'h0000_0001, 0, 0);
        run_vec(32'h8000_0011, 0, 0);
        run_vec(32'hFFFF_FFFF, 1, 0);
        run_vec(32'h0000_0000, 0, 0);

        // load with en low must be ignored
        @(posedge clk); #1;
        en = 1'b0; load = 1'b1; req = 32'h0000_0F00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en0_busy", 32'(busy), 32'd0);
            chk("en0_count", 32'(count), 32'd0);
        end
        @(posedge clk); #1;
        load = 1'b0;

        run_vec(32'h8421_1248, 2, 1);
        run_vec(32'hFFFF_FFFF, 2, 1);
        for (int t = 0; t < 6; t++) begin
            v = (t % 2 == 0) ? ($urandom & $urandom & $urandom) : $urandom;
            run_vec(v, t % 3, 1'(t % 2));
        end

        // reset mid-scan after index 4 of 32'h00F0 has been accepted
        exp_idx.push_back(4);
        @(posedge clk); #1;
        en = 1'b1; load = 1'b1; req = 32'h0000_00F0; out_ready = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_idx.delete();
        exp_cnt.delete();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_idx", 32'(out_idx), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        #13 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_valid", 32'(out_valid), 32'd0);
            chk("postrst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_vec(32'h0000_00F0, 0, 0);

        repeat (3) @(posedge clk);
        chk("leftover_idx", 32'(exp_idx.size()), 32'd0);
        chk("leftover_cnt", 32'(exp_cnt.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
